// File: rtl/scanline_buffer.sv
// Double-buffered scanline store. Tracks the display line from vsync/line strobes, requests and fills the back buffer, swaps at back porch.
// Swap visible one cycle after the line event; producer is stalled via pix_ready, and a late line is aborted and re-requested.
module scanline_buffer #(
  parameter int H_PIXELS     = 640,
  parameter int V_LINES      = 480,
  parameter int V_BACK_LINES = 33
) (
  input  logic                      CLK25MHZ,
  input  logic                      ck_rst_,
  input  logic signed [11:0]        next_y,
  input  logic                      next_line,
  input  logic                      vga_vs,
  output logic                      req_valid,
  input  logic                      req_ready,
  output logic signed [11:0]        req_y,
  output logic                      fill_abort,
  input  logic                      pix_valid,
  output logic                      pix_ready,
  input  logic [11:0]               pix_data,
  output logic [H_PIXELS-1:0][11:0] line_out,
  output logic                      underrun,
  output logic                      sync_err
);

  localparam logic signed [11:0] VL    = 12'(V_LINES);
  localparam logic signed [11:0] VB    = 12'(V_BACK_LINES);
  localparam logic signed [11:0] ZERO  = 12'sd0;
  localparam logic signed [11:0] ONE   = 12'sd1;
  localparam logic [9:0]         XLAST = 10'(H_PIXELS - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_FILL} state_t;

  state_t                    state_q;
  logic                      nl_q, vs_q;
  logic signed [11:0]        up_q, up_d;
  logic                      front_sel_q;
  logic signed [11:0]        tag0_q, tag1_q;
  logic                      full0_q, full1_q;
  logic [H_PIXELS-1:0][11:0] buf0_q, buf1_q;
  logic [9:0]                wr_x_q;
  logic                      req_valid_q, pix_ready_q, underrun_q, sync_err_q;
  logic signed [11:0]        req_y_q;

  logic                      evt, vsr, evt_act;
  logic signed [11:0]        d_line, t_line, front_tag, back_tag, nb_tag;
  logic                      back_full, nb_full, busy, swap, d_act, t_act;
  logic                      have_t, start, tgt_sel, accept, last_beat;
  logic                      underrun_d, sync_err_d;

  always_comb begin
    evt        = nl_q & ~next_line;
    vsr        = ~vs_q & vga_vs;
    evt_act    = evt & ~vsr;
    d_line     = up_q + ONE;
    t_line     = up_q + 12'sd2;
    front_tag  = front_sel_q ? tag1_q : tag0_q;
    back_tag   = front_sel_q ? tag0_q : tag1_q;
    back_full  = front_sel_q ? full0_q : full1_q;
    busy       = (state_q != ST_IDLE);
    swap       = evt_act & back_full & (back_tag == d_line);
    d_act      = (d_line >= ZERO) && (d_line < VL);
    t_act      = (t_line >= ZERO) && (t_line < VL);
    underrun_d = evt_act & d_act & ~swap & (front_tag != d_line);
    // next_y reports the line just finished, which is the tracker value before the increment
    sync_err_d = evt_act & (d_line >= ONE) & (d_line < VL) & (next_y != up_q);
    // After a swap the back buffer is the old front, which is never being filled
    nb_tag     = swap ? front_tag : back_tag;
    nb_full    = swap ? 1'b0 : back_full;
    have_t     = (nb_full | (busy & ~swap)) & (nb_tag == t_line);
    start      = evt_act & t_act & ~have_t;
    tgt_sel    = swap ? front_sel_q : ~front_sel_q;
    accept     = pix_ready_q & pix_valid & ~start;
    last_beat  = accept & (wr_x_q == XLAST);
    up_d       = up_q;
    if (vsr) begin
      up_d = -VB;
    end else if (evt) begin
      up_d = (up_q >= VL) ? VL : up_q + ONE;
    end
  end

  assign req_valid  = req_valid_q;
  assign req_y      = req_y_q;
  assign pix_ready  = pix_ready_q;
  assign fill_abort = start & busy;
  assign underrun   = underrun_q;
  assign sync_err   = sync_err_q;
  assign line_out   = front_sel_q ? buf1_q : buf0_q;

  always_ff @(posedge CLK25MHZ or negedge ck_rst_) begin
    if (!ck_rst_) begin
      state_q     <= ST_IDLE;
      nl_q        <= 1'b0;
      vs_q        <= 1'b0;
      up_q        <= VL;
      front_sel_q <= 1'b0;
      tag0_q      <= '0;
      tag1_q      <= '0;
      full0_q     <= 1'b0;
      full1_q     <= 1'b0;
      buf0_q      <= '0;
      buf1_q      <= '0;
      wr_x_q      <= '0;
      req_valid_q <= 1'b0;
      pix_ready_q <= 1'b0;
      req_y_q     <= '0;
      underrun_q  <= 1'b0;
      sync_err_q  <= 1'b0;
    end else begin
      nl_q       <= next_line;
      vs_q       <= vga_vs;
      up_q       <= up_d;
      underrun_q <= underrun_d;
      sync_err_q <= sync_err_d;

      if (swap) begin
        front_sel_q <= ~front_sel_q;
        if (front_sel_q) full1_q <= 1'b0;
        else             full0_q <= 1'b0;
      end

      if (start) begin
        req_y_q     <= t_line;
        req_valid_q <= 1'b1;
        pix_ready_q <= 1'b0;
        state_q     <= ST_REQ;
        if (tgt_sel) begin
          tag1_q  <= t_line;
          full1_q <= 1'b0;
        end else begin
          tag0_q  <= t_line;
          full0_q <= 1'b0;
        end
      end else begin
        case (state_q)
          ST_IDLE: begin
            req_valid_q <= 1'b0;
            pix_ready_q <= 1'b0;
          end
          ST_REQ: begin
            if (req_ready) begin
              wr_x_q      <= '0;
              req_valid_q <= 1'b0;
              pix_ready_q <= 1'b1;
              state_q     <= ST_FILL;
            end
          end
          ST_FILL: begin
            if (accept) begin
              wr_x_q <= wr_x_q + 10'd1;
              for (int i = 0; i < H_PIXELS; i++) begin
                if (wr_x_q == 10'(i)) begin
                  if (front_sel_q) buf0_q[i] <= pix_data;
                  else             buf1_q[i] <= pix_data;
                end
              end
            end
            if (last_beat) begin
              pix_ready_q <= 1'b0;
              state_q     <= ST_IDLE;
              if (front_sel_q) full0_q <= 1'b1;
              else             full1_q <= 1'b1;
            end
          end
          default: begin
            state_q     <= ST_IDLE;
            req_valid_q <= 1'b0;
            pix_ready_q <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_scanline_buffer.sv
// Directed bench for scanline_buffer: a narrow 32-pixel line keeps a full 480-line frame short.
module tb_scanline_buffer;

  localparam int HP = 32;

  logic                clk = 1'b0;
  logic                rst_n;
  logic signed [11:0]  next_y;
  logic                next_line, vga_vs;
  logic                req_valid, req_ready;
  logic signed [11:0]  req_y;
  logic                fill_abort;
  logic                pix_valid, pix_ready;
  logic [11:0]         pix_data;
  logic [HP-1:0][11:0] line_out;
  logic                underrun, sync_err;

  scanline_buffer #(.H_PIXELS(HP), .V_LINES(480), .V_BACK_LINES(33)) dut (
    .CLK25MHZ  (clk),
    .ck_rst_   (rst_n),
    .next_y    (next_y),
    .next_line (next_line),
    .vga_vs    (vga_vs),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_y     (req_y),
    .fill_abort(fill_abort),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .pix_data  (pix_data),
    .line_out  (line_out),
    .underrun  (underrun),
    .sync_err  (sync_err)
  );

  initial forever #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  // Pulse and level counters sampled mid-cycle
  int n_ur = 0, n_se = 0, n_ab = 0, n_rv = 0;
  initial forever begin
    @(negedge clk);
    if (underrun)   n_ur++;
    if (sync_err)   n_se++;
    if (fill_abort) n_ab++;
    if (req_valid)  n_rv++;
  end

  // Producer: line 0 carries the pixel index, other lines carry the line number
  int                 beat     = 0;
  int                 stall_at = -1;
  logic signed [11:0] cur_y    = 12'sd0;
  initial begin
    req_ready = 1'b0;
    pix_valid = 1'b0;
    pix_data  = '0;
    forever begin
      @(negedge clk);
      req_ready = req_valid;
      if (req_valid) begin
        beat  = 0;
        cur_y = req_y;
      end
      if (pix_ready && beat < HP && beat != stall_at) begin
        pix_valid = 1'b1;
        pix_data  = (cur_y == 12'sd0) ? 12'(beat) : $unsigned(cur_y);
        beat++;
      end else begin
        pix_valid = 1'b0;
      end
    end
  end

  int vy      = 480;
  int force_y = -1;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Raise the line strobe, then drop it; returns one edge after the event is taken
  task automatic line_start();
    next_line = 1'b1;
    tick(8);
    next_y    = (force_y >= 0) ? 12'(force_y) : 12'(vy);
    next_line = 1'b0;
    vy        = (vy >= 480) ? 480 : vy + 1;
    tick(1);
  endtask

  task automatic vsync();
    vga_vs = 1'b1;
    tick(2);
    vga_vs = 1'b0;
    vy     = -33;
    tick(2);
  endtask

  int rv0, ur0, se0, ab0;

  initial begin
    rst_n     = 1'b1;
    next_line = 1'b0;
    vga_vs    = 1'b0;
    next_y    = '0;
    #2 rst_n  = 1'b0;
    tick(3);
    chk("rst_req_valid",  32'(req_valid), 0);
    chk("rst_pix_ready",  32'(pix_ready), 0);
    chk("rst_req_y",      32'(req_y), 0);
    chk("rst_fill_abort", 32'(fill_abort), 0);
    chk("rst_underrun",   32'(underrun), 0);
    chk("rst_sync_err",   32'(sync_err), 0);
    chk("rst_line_zero",  32'(line_out == '0), 1);
    rst_n = 1'b1;
    tick(2);

    // Line strobes without vsync must not trigger requests
    rv0 = n_rv;
    repeat (5) begin
      line_start();
      tick(39);
    end
    chk("pre_vs_no_req",  32'(n_rv - rv0), 0);
    chk("pre_vs_line_zero", 32'(line_out == '0), 1);

    // Frame 1: back porch, then every active line
    vsync();
    ur0 = n_ur; se0 = n_se; ab0 = n_ab;
    for (int k = 1; k <= 32; k++) begin
      line_start();
      if (k == 32) begin
        chk("first_req_valid", 32'(req_valid), 1);
        chk("first_req_y",     32'(req_y), 0);
      end
      tick(39);
    end
    for (int dl = 0; dl < 480; dl++) begin
      line_start();
      tick(1);
      chk("line_px0", 32'(line_out[0]), 32'(dl));
      if (dl == 0) begin
        chk("line0_px5",  32'(line_out[5]), 5);
        chk("line0_last", 32'(line_out[HP-1]), 32'(HP-1));
      end
      tick(38);
    end
    chk("frame_underruns", 32'(n_ur - ur0), 0);
    chk("frame_sync_errs", 32'(n_se - se0), 0);
    chk("frame_aborts",    32'(n_ab - ab0), 0);

    // Frame 2: stall the fill of line 4 mid-line
    vsync();
    for (int k = 1; k <= 36; k++) begin
      line_start();
      if (k == 36) stall_at = 10;
      tick(39);
    end
    ur0 = n_ur; ab0 = n_ab; se0 = n_se;
    line_start();
    stall_at = -1;
    chk("abort_req_valid", 32'(req_valid), 1);
    chk("abort_req_y",     32'(req_y), 6'd5);
    tick(1);
    chk("stall_underrun",  32'(n_ur - ur0), 1);
    chk("stall_abort",     32'(n_ab - ab0), 1);
    chk("stall_stale_px0", 32'(line_out[0]), 3);
    tick(38);

    // Wrong next_y on the line event that shows line 5
    force_y = 7;
    line_start();
    force_y = -1;
    tick(1);
    chk("sync_err_pulse",   32'(n_se - se0), 1);
    chk("sync_line5_px0",   32'(line_out[0]), 5);
    chk("sync_no_underrun", 32'(n_ur - ur0), 1);
    tick(38);

    line_start();
    tick(1);
    chk("line6_px0",       32'(line_out[0]), 6);
    chk("sync_err_single", 32'(n_se - se0), 1);

    // Reset while line 7 is being filled
    tick(5);
    chk("midfill_pix_ready", 32'(pix_ready), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_pix_ready", 32'(pix_ready), 0);
    chk("async_req_valid", 32'(req_valid), 0);
    chk("async_line_zero", 32'(line_out == '0), 1);
    tick(2);
    rst_n = 1'b1;
    vy    = 480;
    tick(2);
    rv0 = n_rv;
    repeat (3) begin
      line_start();
      tick(39);
    end
    chk("post_rst_no_req", 32'(n_rv - rv0), 0);

    vsync();
    for (int k = 1; k <= 32; k++) begin
      line_start();
      if (k == 32) begin
        chk("rereq_valid", 32'(req_valid), 1);
        chk("rereq_y",     32'(req_y), 0);
      end
      tick(39);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
